// File: rtl/ecsm_pkg.sv
// Shared types for the double-and-add scalar multiplication controller.
// Build option: ECSM_CONST_TIME_EN selects the fixed-schedule variant.
package ecsm_pkg;

    localparam int W     = 256;
    localparam int IDX_W = $clog2(W);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } ec_point_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_SCAN     = 4'd2,
        ST_DBL      = 4'd3,
        ST_DBL_WAIT = 4'd4,
        ST_ADD      = 4'd5,
        ST_ADD_WAIT = 4'd6,
        ST_NEXT     = 4'd7,
        ST_DONE     = 4'd8
    } ecsm_state_e;

endpackage

// File: rtl/ec_scalar_mult_ctrl_if.sv
// Host and engine signals of the scalar multiplication controller.
// Engine handshake: o_*_start is a level request held until the engine's done is
// sampled high (result committed that cycle); done must be seen low before the next request.
interface ec_scalar_mult_ctrl_if;
    import ecsm_pkg::*;

    logic         i_start;
    logic [W-1:0] i_k, i_px, i_py, i_pz, i_p;
    logic         o_busy, o_done, o_inf;
    logic [W-1:0] o_x, o_y, o_z, o_p;

    logic         o_dbl_start;
    logic [W-1:0] o_dbl_x, o_dbl_y, o_dbl_z;
    logic         i_dbl_done;
    logic [W-1:0] i_dbl_x, i_dbl_y, i_dbl_z;

    logic         o_add_start;
    logic [W-1:0] o_add_x1, o_add_y1, o_add_z1;
    logic [W-1:0] o_add_x2, o_add_y2, o_add_z2;
    logic         i_add_done;
    logic [W-1:0] i_add_x, i_add_y, i_add_z;

    modport master (
        input  i_start, i_k, i_px, i_py, i_pz, i_p,
        output o_busy, o_done, o_inf, o_x, o_y, o_z, o_p,
        output o_dbl_start, o_dbl_x, o_dbl_y, o_dbl_z,
        input  i_dbl_done, i_dbl_x, i_dbl_y, i_dbl_z,
        output o_add_start, o_add_x1, o_add_y1, o_add_z1, o_add_x2, o_add_y2, o_add_z2,
        input  i_add_done, i_add_x, i_add_y, i_add_z
    );

    modport slave (
        output i_start, i_k, i_px, i_py, i_pz, i_p,
        input  o_busy, o_done, o_inf, o_x, o_y, o_z, o_p,
        input  o_dbl_start, o_dbl_x, o_dbl_y, o_dbl_z,
        output i_dbl_done, i_dbl_x, i_dbl_y, i_dbl_z,
        input  o_add_start, o_add_x1, o_add_y1, o_add_z1, o_add_x2, o_add_y2, o_add_z2,
        output i_add_done, i_add_x, i_add_y, i_add_z
    );

endinterface

// File: rtl/ecsm_kscan.sv
// Scalar register with bit-index walker and top-bit detection.
// Build option: ECSM_CONST_TIME_EN adds a fixed-length scan counter.
module ecsm_kscan
    import ecsm_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_k,
    input  logic         i_scan,
    input  logic         i_dec,
    output logic         o_bit,
    output logic         o_found,
    output logic         o_idx_zero,
    output logic         o_scan_last
);

    logic [W-1:0]     r_k;
    logic [IDX_W-1:0] r_idx;
    logic             r_found;
`ifdef ECSM_CONST_TIME_EN
    logic [IDX_W-1:0] r_cnt;
`endif

    assign o_bit      = r_k[r_idx];
    assign o_found    = r_found;
    assign o_idx_zero = (r_idx == '0);
`ifdef ECSM_CONST_TIME_EN
    assign o_scan_last = (r_cnt == '0);
`else
    assign o_scan_last = o_idx_zero;
`endif

    // Once the top bit is found the index freezes there; only the scan counter keeps running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k     <= '0;
            r_idx   <= '0;
            r_found <= 1'b0;
`ifdef ECSM_CONST_TIME_EN
            r_cnt   <= '0;
`endif
        end else if (i_load) begin
            r_k     <= i_k;
            r_idx   <= IDX_W'(W-1);
            r_found <= 1'b0;
`ifdef ECSM_CONST_TIME_EN
            r_cnt   <= IDX_W'(W-1);
`endif
        end else begin
            if (i_scan && !r_found) begin
                if (o_bit)
                    r_found <= 1'b1;
                else if (!o_idx_zero)
                    r_idx <= r_idx - IDX_W'(1);
            end
`ifdef ECSM_CONST_TIME_EN
            if (i_scan && (r_cnt != '0))
                r_cnt <= r_cnt - IDX_W'(1);
`endif
            if (i_dec)
                r_idx <= r_idx - IDX_W'(1);
        end
    end

endmodule

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving external doubling/addition engines.
// Build option: ECSM_CONST_TIME_EN (full-length scan, ADD every iteration).
module ec_scalar_mult_ctrl
    import ecsm_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ec_scalar_mult_ctrl_if.master bus,
    output logic [3:0]            o_state
);

    localparam logic [3:0] S_IDLE     = ST_IDLE;
    localparam logic [3:0] S_LOAD     = ST_LOAD;
    localparam logic [3:0] S_SCAN     = ST_SCAN;
    localparam logic [3:0] S_DBL      = ST_DBL;
    localparam logic [3:0] S_DBL_WAIT = ST_DBL_WAIT;
    localparam logic [3:0] S_ADD      = ST_ADD;
    localparam logic [3:0] S_ADD_WAIT = ST_ADD_WAIT;
    localparam logic [3:0] S_NEXT     = ST_NEXT;
    localparam logic [3:0] S_DONE     = ST_DONE;

    logic [3:0]   r_state;
    ec_point_t    r_q, r_base;
    logic [W-1:0] r_mod;
    logic         r_done, r_inf, r_dbl_start, r_add_start, r_dbl_rdy, r_add_rdy;
    logic         w_load, w_scan, w_dec, w_bit, w_found, w_idx_zero, w_scan_last;

    assign w_load = (r_state == S_IDLE) && bus.i_start;
    assign w_scan = (r_state == S_SCAN);
    assign w_dec  = (r_state == S_NEXT) && !w_idx_zero;

    ecsm_kscan u_kscan (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_k         (bus.i_k),
        .i_scan      (w_scan),
        .i_dec       (w_dec),
        .o_bit       (w_bit),
        .o_found     (w_found),
        .o_idx_zero  (w_idx_zero),
        .o_scan_last (w_scan_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_base      <= '0;
            r_mod       <= '0;
            r_done      <= 1'b0;
            r_inf       <= 1'b0;
            r_dbl_start <= 1'b0;
            r_add_start <= 1'b0;
            r_dbl_rdy   <= 1'b0;
            r_add_rdy   <= 1'b0;
        end else begin
            // An engine becomes eligible again only after its done has been seen low.
            if (!bus.i_dbl_done) r_dbl_rdy <= 1'b1;
            if (!bus.i_add_done) r_add_rdy <= 1'b1;
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_base  <= '{x: bus.i_px, y: bus.i_py, z: bus.i_pz};
                    r_mod   <= bus.i_p;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_q     <= '0;
                    r_done  <= 1'b0;
                    r_inf   <= 1'b0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!w_found && w_bit) r_q <= r_base;
`ifdef ECSM_CONST_TIME_EN
                    if (w_scan_last) begin
                        if (w_found || w_bit) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_inf   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
`else
                    if (w_bit) begin
                        r_state <= S_NEXT;
                    end else if (w_scan_last) begin
                        r_inf   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`endif
                end
                S_DBL: if (r_dbl_rdy) begin
                    r_dbl_start <= 1'b1;
                    r_state     <= S_DBL_WAIT;
                end
                S_DBL_WAIT: if (bus.i_dbl_done) begin
                    r_q         <= '{x: bus.i_dbl_x, y: bus.i_dbl_y, z: bus.i_dbl_z};
                    r_dbl_start <= 1'b0;
                    r_dbl_rdy   <= 1'b0;
`ifdef ECSM_CONST_TIME_EN
                    r_state     <= S_ADD;
`else
                    r_state     <= w_bit ? S_ADD : S_NEXT;
`endif
                end
                S_ADD: if (r_add_rdy) begin
                    r_add_start <= 1'b1;
                    r_state     <= S_ADD_WAIT;
                end
                S_ADD_WAIT: if (bus.i_add_done) begin
                    if (w_bit) r_q <= '{x: bus.i_add_x, y: bus.i_add_y, z: bus.i_add_z};
                    r_add_start <= 1'b0;
                    r_add_rdy   <= 1'b0;
                    r_state     <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_idx_zero) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DBL;
                    end
                end
                S_DONE: if (!bus.i_start) begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.o_done      = r_done;
    assign bus.o_inf       = r_inf;
    assign bus.o_x         = r_q.x;
    assign bus.o_y         = r_q.y;
    assign bus.o_z         = r_q.z;
    assign bus.o_p         = r_mod;
    assign bus.o_dbl_start = r_dbl_start;
    assign bus.o_dbl_x     = r_q.x;
    assign bus.o_dbl_y     = r_q.y;
    assign bus.o_dbl_z     = r_q.z;
    assign bus.o_add_start = r_add_start;
    assign bus.o_add_x1    = r_q.x;
    assign bus.o_add_y1    = r_q.y;
    assign bus.o_add_z1    = r_q.z;
    assign bus.o_add_x2    = r_base.x;
    assign bus.o_add_y2    = r_base.y;
    assign bus.o_add_z2    = r_base.z;
    assign o_state         = r_state;

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Directed bench for ec_scalar_mult_ctrl with tag-arithmetic engine models
// (DBL: (x,y,z)->(2x,2y,z), ADD: (x1+x2,y1+y2,z1), 5-cycle latency, level done).
module tb_ec_scalar_mult_ctrl;
    import ecsm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] state_dbg;
    int total = 0;
    int bad = 0;

    ec_scalar_mult_ctrl_if bus ();

    ec_scalar_mult_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- engine models ----------------
    int dbl_hold_extra = 0, add_hold_extra = 0;
    logic dbl_busy, add_busy;
    int dbl_cnt, dbl_hold, add_cnt, add_hold;
    ec_point_t dbl_op, add_op1, add_op2;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.i_dbl_done <= 1'b0;
            bus.i_dbl_x <= '0; bus.i_dbl_y <= '0; bus.i_dbl_z <= '0;
            dbl_busy <= 1'b0; dbl_cnt <= 0; dbl_hold <= 0;
        end else if (dbl_busy) begin
            if (dbl_cnt == 1) begin
                dbl_busy <= 1'b0;
                bus.i_dbl_done <= 1'b1;
                bus.i_dbl_x <= dbl_op.x << 1;
                bus.i_dbl_y <= dbl_op.y << 1;
                bus.i_dbl_z <= dbl_op.z;
                dbl_hold <= dbl_hold_extra;
            end else dbl_cnt <= dbl_cnt - 1;
        end else if (bus.i_dbl_done) begin
            if (!bus.o_dbl_start) begin
                if (dbl_hold == 0) bus.i_dbl_done <= 1'b0;
                else dbl_hold <= dbl_hold - 1;
            end
        end else if (bus.o_dbl_start) begin
            dbl_busy <= 1'b1;
            dbl_cnt <= 5;
            dbl_op <= '{x: bus.o_dbl_x, y: bus.o_dbl_y, z: bus.o_dbl_z};
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.i_add_done <= 1'b0;
            bus.i_add_x <= '0; bus.i_add_y <= '0; bus.i_add_z <= '0;
            add_busy <= 1'b0; add_cnt <= 0; add_hold <= 0;
        end else if (add_busy) begin
            if (add_cnt == 1) begin
                add_busy <= 1'b0;
                bus.i_add_done <= 1'b1;
                bus.i_add_x <= add_op1.x + add_op2.x;
                bus.i_add_y <= add_op1.y + add_op2.y;
                bus.i_add_z <= add_op1.z;
                add_hold <= add_hold_extra;
            end else add_cnt <= add_cnt - 1;
        end else if (bus.i_add_done) begin
            if (!bus.o_add_start) begin
                if (add_hold == 0) bus.i_add_done <= 1'b0;
                else add_hold <= add_hold - 1;
            end
        end else if (bus.o_add_start) begin
            add_busy <= 1'b1;
            add_cnt <= 5;
            add_op1 <= '{x: bus.o_add_x1, y: bus.o_add_y1, z: bus.o_add_z1};
            add_op2 <= '{x: bus.o_add_x2, y: bus.o_add_y2, z: bus.o_add_z2};
        end
    end

    // ---------------- start monitor ----------------
    logic [1:0] seq_q[$];
    logic [1:0] exp_q[$];
    int n_dbl, n_add, n_overlap, n_early;
    logic prev_dbl, prev_add;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dbl = 1'b0;
            prev_add = 1'b0;
        end else begin
            if (bus.o_dbl_start && !prev_dbl) begin
                seq_q.push_back(2'd1); n_dbl++;
                if (bus.i_dbl_done) n_early++;
            end
            if (bus.o_add_start && !prev_add) begin
                seq_q.push_back(2'd2); n_add++;
                if (bus.i_add_done) n_early++;
            end
            if (bus.o_dbl_start && bus.o_add_start) n_overlap++;
            prev_dbl = bus.o_dbl_start;
            prev_add = bus.o_add_start;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic run_k(input logic [W-1:0] k, input logic [W-1:0] px, input logic [W-1:0] py,
                         input logic [W-1:0] pz, input logic [W-1:0] p, input bit scramble,
                         output int cyc, output bit timed_out, output logic busy1);
        seq_q.delete();
        n_dbl = 0; n_add = 0; n_overlap = 0; n_early = 0;
        bus.i_k = k; bus.i_px = px; bus.i_py = py; bus.i_pz = pz; bus.i_p = p;
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        cyc = 0; timed_out = 1'b1; busy1 = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) busy1 = bus.o_busy;
            if (scramble && cyc == 2) begin
                bus.i_k = {8{$urandom()}}; bus.i_px = {8{$urandom()}};
                bus.i_py = {8{$urandom()}}; bus.i_p = {8{$urandom()}};
            end
            if (bus.o_done) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic drop_start();
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if ({bus.o_busy, bus.o_done, bus.o_inf, bus.o_dbl_start, bus.o_add_start} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {bus.o_busy, bus.o_done, bus.o_inf, bus.o_dbl_start, bus.o_add_start}); end
        total++; if ({bus.o_x, bus.o_y, bus.o_z} !== '0) begin
            bad++; $display("FAIL reset_q: got %h want 0", bus.o_x); end
        total++; if (bus.o_p !== '0) begin
            bad++; $display("FAIL reset_p: got %h want 0", bus.o_p); end
    endtask

    task automatic test_k0();
        int cyc; bit to; logic b1;
        run_k('0, 256'd1, 256'd2, 256'd7, 256'd97, 1'b0, cyc, to, b1);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL k0_timeout: got timeout want done"); end
        total++; if (cyc !== W + 2) begin bad++; $display("FAIL k0_latency: got %0d want %0d", cyc, W + 2); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL k0_busy_rise: got %b want 1", b1); end
        total++; if (bus.o_inf !== 1'b1) begin bad++; $display("FAIL k0_inf: got %b want 1", bus.o_inf); end
        total++; if ({bus.o_x, bus.o_y, bus.o_z} !== '0) begin
            bad++; $display("FAIL k0_q: got x=%h y=%h z=%h want 0", bus.o_x, bus.o_y, bus.o_z); end
        total++; if (n_dbl + n_add !== 0) begin bad++; $display("FAIL k0_starts: got %0d want 0", n_dbl + n_add); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL k0_busy_done: got %b want 0", bus.o_busy); end
        drop_start();
    endtask

    task automatic test_k1();
        int cyc; bit to; logic b1;
        logic [W-1:0] gx, gy, pm;
        gx = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
        gy = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
        pm = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
        run_k(256'd1, gx, gy, 256'd1, pm, 1'b0, cyc, to, b1);
        total++; if (cyc !== W + 3) begin bad++; $display("FAIL k1_latency: got %0d want %0d", cyc, W + 3); end
        total++; if (bus.o_x !== gx) begin bad++; $display("FAIL k1_x: got %h want %h", bus.o_x, gx); end
        total++; if (bus.o_y !== gy) begin bad++; $display("FAIL k1_y: got %h want %h", bus.o_y, gy); end
        total++; if (bus.o_z !== 256'd1) begin bad++; $display("FAIL k1_z: got %h want 1", bus.o_z); end
        total++; if (bus.o_p !== pm) begin bad++; $display("FAIL k1_p: got %h want %h", bus.o_p, pm); end
        total++; if (bus.o_inf !== 1'b0) begin bad++; $display("FAIL k1_inf: got %b want 0", bus.o_inf); end
        total++; if (n_dbl + n_add !== 0) begin bad++; $display("FAIL k1_starts: got %0d want 0", n_dbl + n_add); end
        drop_start();
    endtask

    task automatic test_k5();
        int cyc; bit to; logic b1;
        logic [1:0] got;
        run_k(256'd5, 256'd1, 256'd2, 256'd7, 256'd97, 1'b1, cyc, to, b1);
        exp_q.delete();
`ifdef ECSM_CONST_TIME_EN
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
`else
        exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
`endif
        total++; if (seq_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL k5_seq_len: got %0d want %0d", seq_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < seq_q.size()) ? seq_q[i] : 2'b11;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL k5_seq[%0d]: got %0d want %0d", i, got, exp_q[i]); end
        end
        total++; if ({bus.o_x, bus.o_y, bus.o_z} !== {256'd5, 256'd10, 256'd7}) begin
            bad++; $display("FAIL k5_q: got x=%h y=%h z=%h want 5,a,7", bus.o_x, bus.o_y, bus.o_z); end
        total++; if (bus.o_p !== 256'd97) begin bad++; $display("FAIL k5_p: got %h want 61", bus.o_p); end
        repeat (3) @(posedge clk);
        #1;
        total++; if ({bus.o_done, bus.o_x} !== {1'b1, 256'd5}) begin
            bad++; $display("FAIL k5_hold: got done=%b x=%h want 1,5", bus.o_done, bus.o_x); end
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.o_done !== 1'b0) begin bad++; $display("FAIL k5_done_drop: got %b want 0", bus.o_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        int cyc; bit to; logic b1;
        logic [W-1:0] kk;
        kk = '1;
        run_k(kk, 256'd1, 256'd2, 256'd7, 256'd97, 1'b0, cyc, to, b1);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL ones_timeout: got timeout want done"); end
        total++; if (n_dbl !== 255) begin bad++; $display("FAIL ones_dbl: got %0d want 255", n_dbl); end
        total++; if (n_add !== 255) begin bad++; $display("FAIL ones_add: got %0d want 255", n_add); end
        total++; if (n_overlap !== 0) begin bad++; $display("FAIL ones_overlap: got %0d want 0", n_overlap); end
        total++; if (bus.o_x !== kk) begin bad++; $display("FAIL ones_x: got %h want %h", bus.o_x, kk); end
        total++; if (bus.o_y !== (kk << 1)) begin bad++; $display("FAIL ones_y: got %h want %h", bus.o_y, kk << 1); end
        total++; if (bus.o_z !== 256'd7) begin bad++; $display("FAIL ones_z: got %h want 7", bus.o_z); end
        drop_start();
    endtask

    task automatic test_done_hold();
        int cyc; bit to; logic b1;
        dbl_hold_extra = 3; add_hold_extra = 3;
        run_k(256'd4, 256'd1, 256'd2, 256'd7, 256'd97, 1'b0, cyc, to, b1);
        total++; if (n_early !== 0) begin bad++; $display("FAIL hold_early_restart: got %0d want 0", n_early); end
        total++; if (n_dbl !== 2) begin bad++; $display("FAIL hold_dbl: got %0d want 2", n_dbl); end
`ifdef ECSM_CONST_TIME_EN
        total++; if (n_add !== 2) begin bad++; $display("FAIL hold_add: got %0d want 2", n_add); end
`else
        total++; if (n_add !== 0) begin bad++; $display("FAIL hold_add: got %0d want 0", n_add); end
`endif
        total++; if ({bus.o_x, bus.o_y, bus.o_z} !== {256'd4, 256'd8, 256'd7}) begin
            bad++; $display("FAIL hold_q: got x=%h y=%h z=%h want 4,8,7", bus.o_x, bus.o_y, bus.o_z); end
        drop_start();
        dbl_hold_extra = 0; add_hold_extra = 0;
    endtask

    task automatic test_reset_mid();
        int cyc; bit to; logic b1;
        bit seen;
        bus.i_k = 256'd5; bus.i_px = 256'd1; bus.i_py = 256'd2; bus.i_pz = 256'd7; bus.i_p = 256'd97;
        bus.i_start = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (bus.o_dbl_start) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_dbl_seen: got 0 want 1"); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.o_busy, bus.o_done, bus.o_inf, bus.o_dbl_start, bus.o_add_start} !== 5'b0) begin
            bad++; $display("FAIL rmid_flags: got %b want 00000", {bus.o_busy, bus.o_done, bus.o_inf, bus.o_dbl_start, bus.o_add_start}); end
        total++; if ({bus.o_x, bus.o_p} !== '0) begin
            bad++; $display("FAIL rmid_data: got x=%h p=%h want 0", bus.o_x, bus.o_p); end
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_k(256'd3, 256'd1, 256'd2, 256'd7, 256'd97, 1'b0, cyc, to, b1);
        total++; if ({bus.o_x, bus.o_y, bus.o_z} !== {256'd3, 256'd6, 256'd7}) begin
            bad++; $display("FAIL rmid_k3_q: got x=%h y=%h z=%h want 3,6,7", bus.o_x, bus.o_y, bus.o_z); end
        drop_start();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_k = '0; bus.i_px = '0; bus.i_py = '0; bus.i_pz = '0; bus.i_p = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_k0();
        test_k1();
        test_k5();
        test_all_ones();
        test_done_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
